// File: rtl/ps2_key_mapper.sv
// rtl/ps2_key_mapper.sv - PS/2 Set-2 scan codes to synth note/control events; optional PS2_TYPEMATIC_FILTER_EN
// Define PS2_TYPEMATIC_FILTER_EN to suppress auto-repeat makes of held keys.
module ps2_key_mapper #(
  parameter logic [1:0] DEFAULT_SEL = 2'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ps2_byte,
  input  logic       ps2_byte_valid,
  output logic       note_in,
  output logic [3:0] note,
  output logic       octave_plus_plus,
  output logic       octave_minus_minus,
  output logic       amp_plus_plus,
  output logic       amp_minus_minus,
  output logic [1:0] ADSR_selector,
  output logic       ADSR_plus_plus,
  output logic       ADSR_minus_minus
);

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  state_t      state;
  logic [12:0] note_held;
  logic [5:0]  ctrl_held;
  logic [5:0]  pulse;

  logic       is_make;
  logic       is_break;
  logic       note_hit;
  logic [3:0] note_idx;
  logic       ctrl_hit;
  logic [2:0] ctrl_idx;
  logic       sel_hit;
  logic [1:0] sel_val;

  // Pulse bit order: octave-, octave+, amp-, amp+, ADSR-, ADSR+.
  assign octave_minus_minus = pulse[0];
  assign octave_plus_plus   = pulse[1];
  assign amp_minus_minus    = pulse[2];
  assign amp_plus_plus      = pulse[3];
  assign ADSR_minus_minus   = pulse[4];
  assign ADSR_plus_plus     = pulse[5];

  always_comb begin
    note_hit = 1'b1;
    note_idx = 4'd0;
    case (ps2_byte)
      8'h1C: note_idx = 4'd0;
      8'h1D: note_idx = 4'd1;
      8'h1B: note_idx = 4'd2;
      8'h24: note_idx = 4'd3;
      8'h23: note_idx = 4'd4;
      8'h2B: note_idx = 4'd5;
      8'h2C: note_idx = 4'd6;
      8'h34: note_idx = 4'd7;
      8'h35: note_idx = 4'd8;
      8'h33: note_idx = 4'd9;
      8'h3C: note_idx = 4'd10;
      8'h3B: note_idx = 4'd11;
      8'h42: note_idx = 4'd12;
      default: note_hit = 1'b0;
    endcase
  end

  always_comb begin
    ctrl_hit = 1'b1;
    ctrl_idx = 3'd0;
    case (ps2_byte)
      8'h1A: ctrl_idx = 3'd0;
      8'h22: ctrl_idx = 3'd1;
      8'h21: ctrl_idx = 3'd2;
      8'h2A: ctrl_idx = 3'd3;
      8'h4E: ctrl_idx = 3'd4;
      8'h55: ctrl_idx = 3'd5;
      default: ctrl_hit = 1'b0;
    endcase
  end

  always_comb begin
    sel_hit = 1'b1;
    sel_val = 2'd0;
    case (ps2_byte)
      8'h16: sel_val = 2'd0;
      8'h1E: sel_val = 2'd1;
      8'h26: sel_val = 2'd2;
      8'h25: sel_val = 2'd3;
      default: sel_hit = 1'b0;
    endcase
  end

  always_comb begin
    is_make  = 1'b0;
    is_break = 1'b0;
    if (ps2_byte_valid) begin
      if (state == IDLE) begin
        case (ps2_byte)
          8'hF0, 8'hE0, 8'hAA, 8'hFA, 8'hFE, 8'hEE: is_make = 1'b0;
          default: is_make = 1'b1;
        endcase
      end
      is_break = (state == BRK);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      note_held     <= '0;
      ctrl_held     <= '0;
      note_in       <= 1'b0;
      note          <= 4'd0;
      pulse         <= '0;
      ADSR_selector <= DEFAULT_SEL;
    end else begin
      pulse <= '0;

      if (ps2_byte_valid) begin
        case (state)
          IDLE: begin
            if (ps2_byte == 8'hF0)
              state <= BRK;
            else if (ps2_byte == 8'hE0)
              state <= EXT;
          end
          BRK:     state <= IDLE;
          EXT:     state <= (ps2_byte == 8'hF0) ? EXT_BRK : IDLE;
          default: state <= IDLE;
        endcase
      end

      if (is_make) begin
        if (note_hit) begin
          note_held[note_idx] <= 1'b1;
`ifdef PS2_TYPEMATIC_FILTER_EN
          if (!(note_in && note == note_idx)) begin
            note    <= note_idx;
            note_in <= 1'b1;
          end
`else
          note    <= note_idx;
          note_in <= 1'b1;
`endif
        end
        if (ctrl_hit) begin
          ctrl_held[ctrl_idx] <= 1'b1;
`ifdef PS2_TYPEMATIC_FILTER_EN
          if (!ctrl_held[ctrl_idx])
            pulse[ctrl_idx] <= 1'b1;
`else
          pulse[ctrl_idx] <= 1'b1;
`endif
        end
        if (sel_hit)
          ADSR_selector <= sel_val;
      end

      // Only releasing the sounding note closes the gate; older held notes are just forgotten.
      if (is_break) begin
        if (note_hit) begin
          note_held[note_idx] <= 1'b0;
          if (note_idx == note)
            note_in <= 1'b0;
        end
        if (ctrl_hit)
          ctrl_held[ctrl_idx] <= 1'b0;
      end
    end
  end

endmodule
